// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate type and window helper.
// Used by the sync generator and by the text/pixel generators that consume x/y.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int VGA_CLK_DIV   = 4;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Inclusive sync pulse windows (656..751 and 490..491 for the default mode)
  localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Divides the system clock into a one-cycle pixel enable, high once every
// CLK_DIV cycles, first asserting CLK_DIV cycles after reset release.
module vga_pixel_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      p_tick  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel enable, x/y scan counters, sync and blanking.
// Define VGA_SYNC_FRAME_CNT_EN to add a 60-frame counter driving sec_tick.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV     = VGA_CLK_DIV,
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         p_tick,
  output logic [9:0]   x,
  output logic [9:0]   y,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         frame_start,
  output logic         sec_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  coord_t h_cnt, v_cnt;
  coord_t h_next, v_next;
  logic   line_end, frame_end;

  vga_pixel_div #(.CLK_DIV(CLK_DIV)) u_pixel_div (
    .clk    (clk),
    .rst    (rst),
    .p_tick (p_tick)
  );

  always_comb begin
    line_end  = (h_cnt == H_LAST);
    frame_end = line_end && (v_cnt == V_LAST);
    h_next    = h_cnt;
    v_next    = v_cnt;
    if (p_tick) begin
      if (line_end) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_next = h_cnt + coord_t'(1);
      end
    end
  end

  // Decode from the next counts so the registered flags line up with x/y
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hsync       <= in_window(h_next, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= in_window(v_next, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on    <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
      frame_start <= p_tick && frame_end;
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [5:0] frame_cnt;

  // sec_tick rides on the frame_start that takes frame_cnt from 59 back to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      sec_tick  <= 1'b0;
    end else begin
      sec_tick <= p_tick && frame_end && (frame_cnt == 6'd59);
      if (frame_start) begin
        frame_cnt <= (frame_cnt == 6'd59) ? 6'd0 : frame_cnt + 6'd1;
      end
    end
  end
`else
  assign sec_tick = 1'b0;
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator that produces the pixel coordinates, sync pulses and blanking flag consumed by the text overlay and the other pixel-colour generators. It divides the system clock down to a pixel-rate enable, scans horizontal and vertical counters through a 640x480@60 Hz frame, and decodes the sync and visible-area windows. Everything downstream that takes `x`/`y` is driven from this block.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz); legal range ≥ 2.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_ACTIVE`, 1'b0: level of `hsync`/`vsync` during the sync pulse.

Ports:
- `clk`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `p_tick`, out, 1: one-`clk` pixel enable, high once every `CLK_DIV` cycles.
- `x`, out, 10: current horizontal count, 0..H_TOTAL-1.
- `y`, out, 10: current vertical count, 0..V_TOTAL-1.
- `hsync`, out, 1: horizontal sync.
- `vsync`, out, 1: vertical sync.
- `video_on`, out, 1: high when `x` < H_VISIBLE and `y` < V_VISIBLE.
- `frame_start`, out, 1: one-`clk` pulse when the counters wrap to (0,0).
- `sec_tick`, out, 1: one-`clk` pulse once per 60 frames. Only active under the macro in Configuration.

## Operation
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Clock divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `p_tick` is registered and asserts in the cycle after `div_cnt` = CLK_DIV-1.
- Horizontal counter `h_cnt` advances only on `p_tick`.
  - Increments; at H_TOTAL-1 it wraps to 0 and raises the line-end condition.
- Vertical counter `v_cnt` advances only on `p_tick` with line-end.
  - Increments; at V_TOTAL-1 it wraps to 0.
- Simultaneous wrap: at (799,524) with `p_tick`, both counters go to (0,0) on the same edge, and `frame_start` pulses in that same cycle.
- Outputs:
  - `x` = `h_cnt`, `y` = `v_cnt`.
  - `hsync` = SYNC_ACTIVE when `h_cnt` is in [656,751], otherwise the inverse.
  - `vsync` = SYNC_ACTIVE when `v_cnt` is in [490,491], otherwise the inverse.
- `hsync`, `vsync` and `video_on` are registered. They are computed from the next-state counts so they align in the same cycle as the `x`/`y` they describe.
- Between ticks all outputs hold their values.

## Timing
- Reset values, all applied on the first `clk` edge with `rst` high:
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0, so `x`=0 and `y`=0.
  - `p_tick`=0, `frame_start`=0, `sec_tick`=0.
  - `video_on`=1.
  - `hsync` and `vsync` = ~SYNC_ACTIVE.
- Reset mid-frame: on the next edge every register returns to its reset value.
- First after reset: the first `p_tick` occurs CLK_DIV cycles after `rst` deasserts.
- Advance latency: `x`/`y` advance on the `clk` edge where `p_tick` is high. New values are visible the following cycle.
- Periods: line = 800×CLK_DIV `clk` cycles; frame = 525 lines = 1,680,000 `clk` cycles at CLK_DIV=4.
- Width rules: `h_cnt` and `v_cnt` are 10 bits; H_TOTAL and V_TOTAL must each be ≤ 1024.

## Configuration
- Macro: `VGA_SYNC_FRAME_CNT_EN`.
- Defined:
  - A 6-bit `frame_cnt` counts 0..59. It increments on `frame_start` and wraps 59→0.
  - `sec_tick` pulses in the same cycle as the `frame_start` that wraps 59→0.
  - `frame_cnt` resets to 0. This provides a 1 Hz base for the game timer's `seconds`.
- Undefined: `frame_cnt` logic is absent and `sec_tick` is tied to 0.

## Structure
- Package `vga_pkg` holds:
  - the timing constants and the derived H_TOTAL/V_TOTAL;
  - the sync start and end positions;
  - the coordinate width (10).
- `vga_pkg` is shared with the text and pixel generators.
- Sub-module `vga_pixel_div` contains the divider and `p_tick` generation. It has parameter CLK_DIV and ports `clk`, `rst`, `p_tick`.
- Counters and decode live in the top module.

## Test plan
- Pixel tick: reset, release → `p_tick` first high 4 cycles later, then every 4 cycles; `x`=0,1,2 on successive ticks.
- Horizontal sync window: run one line → `hsync` low exactly while `x` = 656..751 (96 ticks); `video_on` falls at `x`=640; `y` increments when `x` wraps 799→0.
- Vertical sync and frame wrap: run one full frame → `vsync` low for `y` = 490..491; at (799,524)+tick the counters read (0,0) and `frame_start` pulses for exactly one `clk`; frame = 1,680,000 `clk` cycles.
- Mid-frame reset: assert `rst` at `x`=300,`y`=200 for one cycle → next cycle `x`=0, `y`=0, `hsync`=`vsync`=1, `p_tick`=0.
- Frame counter: with `VGA_SYNC_FRAME_CNT_EN`, run 120 frames → `sec_tick` pulses twice, coinciding with the 60th and 120th `frame_start`; without the macro `sec_tick` stays 0.
- Polarity: `SYNC_ACTIVE`=1 → `hsync` high only for `x` 656..751; reset value 0.
